cic_comp_fir: RTL and testbench
===============================

Name: cic_comp_fir

Overview:
- Time-multiplexed, single-MAC FIR that sits directly downstream of the 5-stage CIC decimator.
- Consumes the CIC's 12-bit signed output and its square-wave decimated-rate clock.
- Applies a runtime-loadable compensation response (droop correction / channel shaping).
- Produces a rounded, gain-shifted 12-bit sample with a one-cycle valid strobe for the demodulator stage.

Parameters:
TAPS, 16, number of FIR taps and MAC cycles per output; power of two, 4..64.
DATA_WIDTH, 12, signed width of input and output samples.
COEF_WIDTH, 12, signed coefficient width.
ACC_WIDTH, 32, signed accumulator width; must be at least DATA_WIDTH+COEF_WIDTH+log2(TAPS).
OUT_SHIFT, 10, arithmetic right shift applied to the accumulator before output.

Ports:
clk  in  1  system clock; the CIC clock domain.
rst_n  in  1  synchronous, active-low reset.
d_in  in  DATA_WIDTH  signed sample from the CIC output.
d_clk_in  in  1  CIC decimated clock, used as a level signal; its rising edge marks a new sample.
coef_we  in  1  coefficient write enable.
coef_addr  in  log2(TAPS)  coefficient index k.
coef_data  in  COEF_WIDTH  signed coefficient value.
d_out  out  DATA_WIDTH  signed filtered sample.
d_valid  out  1  one-cycle strobe marking a new d_out.
busy  out  1  high while in the MAC or OUT state.
overrun  out  1  sticky: a sample edge arrived while busy.

Behaviour:
- Clocking and reset: single clock. When rst_n=0 at a clk edge:
  - d_out=0, d_valid=0, busy=0, overrun=0.
  - Sample buffer all zeros; write pointer 0; accumulator 0; state IDLE.
  - Coefficients reset to c[0]=2^OUT_SHIFT and all others 0, giving unity passthrough.
  - Reset mid-operation aborts the current MAC; no d_valid is produced for it.
- Edge detect: d_clk_in is registered to d_clk_q every cycle. A new sample is defined as d_clk_in=1 and d_clk_q=0 at a clk edge (edge t0).
- State IDLE:
  - On a new-sample edge at t0: d_in is written into the circular buffer at wr_ptr, wr_ptr advances, acc is cleared, tap counter k=0, state goes to MAC, busy=1.
- State MAC, exactly TAPS cycles (edges t1..tTAPS):
  - Each cycle computes acc += c[k] * x[n-k], with x[n] being the sample just written.
  - Buffer read index is (newest_ptr - k) mod TAPS, so wrap-around is natural.
  - After k=TAPS-1, state goes to OUT.
- State OUT, edge t(TAPS+1):
  - r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, i.e. round half up.
  - d_out is the saturated or wrapped r (see Optional Feature), d_valid=1, busy=0, state goes to IDLE.
  - d_valid is high for exactly one cycle. d_out holds its value until the next OUT.
  - Latency from sample edge t0 to d_valid is TAPS+1 clocks.
- Overrun: a new-sample edge while busy=1 drops that sample (buffer and pointer unchanged) and sets overrun=1 until reset. The CIC DECIMATION_RATIO must be at least TAPS+2 to avoid this.
- Coefficient writes:
  - Accepted only when the state is IDLE and no new-sample edge occurs in the same cycle: c[coef_addr] <= coef_data.
  - Writes in any other cycle are ignored, so coefficients are stable for a whole MAC.
  - A sample edge and coef_we in the same IDLE cycle: the sample wins and the write is dropped.
- Arithmetic:
  - Each product is a full-precision signed DATA_WIDTH+COEF_WIDTH value, sign-extended to ACC_WIDTH.
  - The accumulator does not wrap for legal parameter choices.

Optional Feature:
- Macro: CIC_COMP_SAT_EN.
- Defined: r is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: d_out = r[DATA_WIDTH-1:0] (two's-complement wrap). This saves the comparators.

Test Plan:
1. Reset, then samples 100 and -37 on successive d_clk_in rising edges -> d_out=100 then -37; each d_valid is a single-cycle pulse exactly 17 clocks after its edge.
2. Load c[0..3]=256, c[4..15]=0 in IDLE, then feed 400,400,400,400 -> d_out=100,200,300,400.
3. c[0]=2047, others 0; input 2047 -> d_out=2047 with CIC_COMP_SAT_EN, -4 without. Input -2048 -> -2048 with the macro, 2 without.
4. Two d_clk_in rising edges 5 clocks apart -> second sample dropped, overrun=1 and held, only one d_valid. The next legal edge with input 60 (passthrough) -> d_out=60.
5. Pulse rst_n low for one cycle at MAC cycle 8 -> no d_valid, d_out=0, overrun=0, coefficients back to passthrough. The next sample 50 -> d_out=50.
6. Pulse coef_we with c[0]=0 during MAC -> ignored; the current and next outputs still equal their inputs (passthrough).

Source files
------------

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: single-MAC compensation FIR behind the CIC decimator; define CIC_COMP_SAT_EN for a saturating output instead of wrapping
module cic_comp_fir #(
  parameter int TAPS       = 16,
  parameter int DATA_WIDTH = 12,
  parameter int COEF_WIDTH = 12,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_SHIFT  = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [DATA_WIDTH-1:0]  d_in,
  input  logic                          d_clk_in,
  input  logic                          coef_we,
  input  logic [$clog2(TAPS)-1:0]       coef_addr,
  input  logic signed [COEF_WIDTH-1:0]  coef_data,
  output logic signed [DATA_WIDTH-1:0]  d_out,
  output logic                          d_valid,
  output logic                          busy,
  output logic                          overrun
);
  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) << (OUT_SHIFT - 1);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t                       state_q, state_d;
  logic                         d_clk_q, new_smp, take, c_wr;
  logic [AW-1:0]                wr_q, k_q, k_d, rd_idx;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, r;
  logic signed [PW-1:0]         prod;
  logic signed [DATA_WIDTH-1:0] x_q [TAPS];
  logic signed [COEF_WIDTH-1:0] c_q [TAPS];
  logic signed [DATA_WIDTH-1:0] d_out_q, d_out_d, d_sat;
  logic                         d_valid_q, overrun_q;
  assign new_smp = d_clk_in & ~d_clk_q;
  assign take    = new_smp && state_q == IDLE;
  assign c_wr    = coef_we && state_q == IDLE && !new_smp;
  assign rd_idx  = wr_q - AW'(1) - k_q;
  assign prod    = PW'(c_q[k_q]) * PW'(x_q[rd_idx]);
  assign r       = (acc_q + HALF) >>> OUT_SHIFT;
`ifdef CIC_COMP_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] MAXV = (ACC_WIDTH'(1) << (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] MINV = -(ACC_WIDTH'(1) << (DATA_WIDTH - 1));
  assign d_sat = r > MAXV ? DATA_WIDTH'(MAXV) : r < MINV ? DATA_WIDTH'(MINV) : DATA_WIDTH'(r);
`else
  assign d_sat = DATA_WIDTH'(r);
`endif
  assign d_out   = d_out_q;
  assign d_valid = d_valid_q;
  assign busy    = state_q != IDLE;
  assign overrun = overrun_q;
  // sample-clock history for rising-edge detection; a stale value after reset only delays one edge
  always_ff @(posedge clk)
    d_clk_q <= d_clk_in;
  // sequencer: IDLE waits for a sample edge, MAC runs one tap per cycle, OUT rounds and publishes
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    d_out_d = d_out_q;
    case (state_q)
      IDLE: if (new_smp) begin
        state_d = MAC;
        k_d     = '0;
        acc_d   = '0;
      end
      MAC: begin
        acc_d = acc_q + ACC_WIDTH'(prod);
        k_d   = k_q + AW'(1);
        if (k_q == AW'(TAPS - 1)) state_d = OUT;
      end
      default: begin
        d_out_d = d_sat;
        state_d = IDLE;
      end
    endcase
  end
  // state, sample ring, coefficient bank and sticky overrun flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      acc_q     <= '0;
      wr_q      <= '0;
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
      c_q[0] <= COEF_WIDTH'(1 << OUT_SHIFT);
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      d_out_q   <= d_out_d;
      d_valid_q <= state_q == OUT;
      if (take) begin
        x_q[wr_q] <= d_in;
        wr_q      <= wr_q + AW'(1);
      end
      if (new_smp && state_q != IDLE) overrun_q <= 1'b1;
      if (c_wr) c_q[coef_addr] <= coef_data;
    end
  end
endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: scoreboard bench for the CIC compensation FIR
module tb_cic_comp_fir;
  localparam int TAPS = 16;
  localparam int LAT  = TAPS + 1;
`ifdef CIC_COMP_SAT_EN
  localparam int E_POS = 2047;
  localparam int E_NEG = -2048;
`else
  localparam int E_POS = -4;
  localparam int E_NEG = 2;
`endif
  logic clk = 1'b0, rst_n = 1'b0, d_clk_in = 1'b0, coef_we = 1'b0;
  logic signed [11:0] d_in = '0, coef_data = '0;
  logic [3:0] coef_addr = '0;
  logic signed [11:0] d_out;
  logic d_valid, busy, overrun;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic signed [11:0] exp_q[$];
  int t_q[$];
  cic_comp_fir dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_clk_in(d_clk_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .d_out(d_out), .d_valid(d_valid), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    d_clk_in = 1'b0;
    coef_we = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic write_coef(input int a, input int d);
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 4'(a);
    coef_data = 12'(d);
    @(negedge clk);
    coef_we = 1'b0;
  endtask
  task automatic edge_sample(input int v, input int e, input bit push);
    @(negedge clk);
    d_in = 12'(v);
    d_clk_in = 1'b1;
    if (push) begin
      exp_q.push_back(12'(e));
      t_q.push_back(cyc + 1 + LAT);
    end
  endtask
  task automatic drain(input string name);
    logic signed [11:0] e;
    int t;
    bit got;
    got = 1'b0;
    e = exp_q.pop_front();
    t = t_q.pop_front();
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (d_valid === 1'b1) begin
        got = 1'b1;
        n_cmp++;
        if (d_out !== e) begin
          n_err++;
          $display("FAIL %s_value: got %0d expected %0d", name, d_out, e);
        end
        n_cmp++;
        if (cyc != t) begin
          n_err++;
          $display("FAIL %s_latency: valid at cycle %0d expected %0d", name, cyc, t);
        end
      end
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s_timeout: no d_valid within 40 cycles, expected %0d", name, e);
    end else begin
      @(negedge clk);
      if (d_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s_pulse: d_valid %b one cycle later, expected 0", name, d_valid);
      end
    end
  endtask
  task automatic quiet(input int n, input string name);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (d_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL %s_quiet: got unexpected d_valid, expected none for %0d cycles", name, n);
    end
  endtask
  task automatic send(input int v, input int e, input string name);
    edge_sample(v, e, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s_busy: got %b expected 1", name, busy);
    end
    repeat (3) @(negedge clk);
    d_clk_in = 1'b0;
    repeat (4) @(negedge clk);
    drain(name);
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (d_out !== 12'sd0) begin n_err++; $display("FAIL reset_d_out: got %0d expected 0", d_out); end
    n_cmp++;
    if (d_valid !== 1'b0) begin n_err++; $display("FAIL reset_d_valid: got %b expected 0", d_valid); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask
  task automatic test_passthrough();
    send(100, 100, "pass_100");
    send(-37, -37, "pass_m37");
  endtask
  task automatic test_coef_load();
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, i < 4 ? 256 : 0);
    send(400, 100, "avg_1");
    send(400, 200, "avg_2");
    send(400, 300, "avg_3");
    send(400, 400, "avg_4");
  endtask
  task automatic test_saturation();
    do_reset();
    write_coef(0, 2047);
    send(2047, E_POS, "sat_pos");
    send(-2048, E_NEG, "sat_neg");
  endtask
  task automatic test_overrun();
    do_reset();
    edge_sample(10, 10, 1'b1);
    @(negedge clk);
    d_clk_in = 1'b0;
    repeat (4) @(negedge clk);
    d_in = 12'sd77;
    d_clk_in = 1'b1;
    @(negedge clk);
    d_clk_in = 1'b0;
    n_cmp++;
    if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    drain("ovr_first");
    quiet(20, "ovr_dropped");
    n_cmp++;
    if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_hold: got %b expected 1", overrun); end
    send(60, 60, "ovr_next");
    n_cmp++;
    if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
  endtask
  task automatic test_reset_mid_mac();
    write_coef(0, 512);
    edge_sample(30, 0, 1'b0);
    repeat (3) @(negedge clk);
    d_clk_in = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (d_out !== 12'sd0) begin n_err++; $display("FAIL midrst_d_out: got %0d expected 0", d_out); end
    n_cmp++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL midrst_overrun: got %b expected 0", overrun); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    quiet(25, "midrst_abort");
    send(50, 50, "midrst_next");
  endtask
  task automatic test_coef_lockout();
    edge_sample(70, 70, 1'b1);
    repeat (2) @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 4'd0;
    coef_data = 12'sd0;
    @(negedge clk);
    coef_we = 1'b0;
    repeat (2) @(negedge clk);
    d_clk_in = 1'b0;
    repeat (3) @(negedge clk);
    drain("lock_mac_cur");
    send(71, 71, "lock_mac_next");
    edge_sample(80, 80, 1'b1);
    coef_we = 1'b1;
    coef_addr = 4'd0;
    coef_data = 12'sd0;
    @(negedge clk);
    coef_we = 1'b0;
    repeat (3) @(negedge clk);
    d_clk_in = 1'b0;
    repeat (4) @(negedge clk);
    drain("lock_edge_cur");
    send(81, 81, "lock_edge_next");
  endtask
  initial begin
    test_reset();
    test_passthrough();
    test_coef_load();
    test_saturation();
    test_overrun();
    test_reset_mid_mac();
    test_coef_lockout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
